// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-flop synchroniser, majority-of-3 bit sampling, parity and
// framing checks, and a show-ahead FIFO of received words with overrun pulse.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 261,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          RX,
  output logic [DATA_BITS-1:0]          RX_DATA,
  output logic                          RX_PERR,
  output logic                          RX_FERR,
  output logic                          RX_VALID,
  input  logic                          RX_READY,
  output logic [$clog2(FIFO_DEPTH):0]   COUNT,
  output logic                          OVERRUN,
  output logic                          BUSY
);

  // state    | meaning
  // S_IDLE   | line idle, waiting for rx_s low
  // S_START  | start bit; a high vote is a glitch
  // S_DATA   | payload bits, LSB first
  // S_PARITY | parity bit check
  // S_STOP   | stop bit(s); push at the last stop vote
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  localparam int M  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = DATA_BITS + 2;

  state_t               state_q;
  logic                 busy_q;
  logic                 rx_meta_q, rx_s_q;
  logic [CW-1:0]        cnt_q;
  logic [BW-1:0]        bit_q;
  logic                 stop_q;
  logic                 s0_q, s1_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 perr_q, ferr_q;

  logic [WW-1:0]        mem_q [FIFO_DEPTH];
  logic [AW-1:0]        rd_ptr_q, wr_ptr_q;
  logic [AW:0]          count_q;
  logic                 ovr_q;

  logic          at_vote, bit_end, vote, par_exp, last_stop;
  logic          push_d, pop_d, full_d, wr_en_d, ovr_d;
  logic [WW-1:0] word_d, head_d;

  assign at_vote   = (cnt_q == CW'(M + 1));
  assign bit_end   = (cnt_q == CW'(CLKS_PER_BIT - 1));
  assign vote      = (s0_q & s1_q) | (s0_q & rx_s_q) | (s1_q & rx_s_q);
  assign par_exp   = (PARITY == 1) ? ~(^shift_q) : ^shift_q;
  assign last_stop = (STOP_BITS == 1) || stop_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      bit_q     <= '0;
      stop_q    <= 1'b0;
      s0_q      <= 1'b1;
      s1_q      <= 1'b1;
      shift_q   <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= RX;
      rx_s_q    <= rx_meta_q;
      if (cnt_q == CW'(M - 1)) s0_q <= rx_s_q;
      if (cnt_q == CW'(M))     s1_q <= rx_s_q;
      cnt_q <= bit_end ? '0 : cnt_q + CW'(1);
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (!rx_s_q) begin
            state_q <= S_START;
            busy_q  <= 1'b1;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
          end
        end
        S_START: begin
          if (at_vote && vote) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (bit_end) begin
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (at_vote) shift_q <= {vote, shift_q[DATA_BITS-1:1]};
          if (bit_end) begin
            if (bit_q == BW'(DATA_BITS - 1)) begin
              bit_q   <= '0;
              state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_q <= bit_q + BW'(1);
            end
          end
        end
        S_PARITY: begin
          if (at_vote) perr_q <= (vote != par_exp);
          if (bit_end) state_q <= S_STOP;
        end
        S_STOP: begin
          if (at_vote) begin
            if (!vote) ferr_q <= 1'b1;
            // leave at the vote so a start edge in the last half-bit is caught
            if (last_stop) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else if (bit_end) begin
            stop_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign push_d  = (state_q == S_STOP) && at_vote && last_stop;
  assign word_d  = {ferr_q | ~vote, perr_q, shift_q};
  assign pop_d   = RX_VALID & RX_READY;
  assign full_d  = (count_q == (AW + 1)'(FIFO_DEPTH));
  assign wr_en_d = push_d & (~full_d | pop_d);
  assign ovr_d   = push_d & full_d & ~pop_d;

  always_ff @(posedge CLK) begin
    if (wr_en_d) mem_q[wr_ptr_q] <= word_d;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
    end else begin
      ovr_q <= ovr_d;
      if (wr_en_d) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_d)   rd_ptr_q <= rd_ptr_q + AW'(1);
      if (wr_en_d && !pop_d)      count_q <= count_q + (AW + 1)'(1);
      else if (!wr_en_d && pop_d) count_q <= count_q - (AW + 1)'(1);
    end
  end

  assign head_d   = mem_q[rd_ptr_q];
  assign RX_VALID = (count_q != '0);
  assign RX_DATA  = RX_VALID ? head_d[DATA_BITS-1:0] : '0;
  assign RX_PERR  = RX_VALID ? head_d[DATA_BITS]     : 1'b0;
  assign RX_FERR  = RX_VALID ? head_d[DATA_BITS+1]   : 1'b0;
  assign COUNT    = count_q;
  assign OVERRUN  = ovr_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: a frame-level model (expected push cycle, word queue,
// busy windows) compared every cycle, plus hand-computed literal checks.
module tb_uart_rx_fifo;
  localparam int NI = 2;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       rx      [NI];
  logic       rdy     [NI];
  logic [7:0] rx_data [NI];
  logic       perr    [NI];
  logic       ferr    [NI];
  logic       valid   [NI];
  logic [2:0] count   [NI];
  logic       ovr     [NI];
  logic       busy    [NI];

  always #10 CLK = ~CLK;

  uart_rx_fifo #(.CLKS_PER_BIT(261)) u_a (
    .CLK(CLK), .RESET(RESET), .RX(rx[0]), .RX_DATA(rx_data[0]), .RX_PERR(perr[0]),
    .RX_FERR(ferr[0]), .RX_VALID(valid[0]), .RX_READY(rdy[0]), .COUNT(count[0]),
    .OVERRUN(ovr[0]), .BUSY(busy[0]));

  uart_rx_fifo #(.CLKS_PER_BIT(16), .PARITY(2), .STOP_BITS(2)) u_b (
    .CLK(CLK), .RESET(RESET), .RX(rx[1]), .RX_DATA(rx_data[1]), .RX_PERR(perr[1]),
    .RX_FERR(ferr[1]), .RX_VALID(valid[1]), .RX_READY(rdy[1]), .COUNT(count[1]),
    .OVERRUN(ovr[1]), .BUSY(busy[1]));

  typedef struct { int cyc; logic [7:0] d; logic pe; logic fe; } ent_t;
  typedef struct { int lo; int hi; } iv_t;

  ent_t pend [NI][$];
  ent_t mq   [NI][$];
  iv_t  biv  [NI][$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic rdy_cap [NI];
  logic prev_valid [NI];
  int   rise_cyc [NI];
  int   ovr_cnt  [NI];

  function automatic int cpb(input int i);   return (i == 0) ? 261 : 16; endfunction
  function automatic int npar(input int i);  return (i == 0) ? 0 : 1;    endfunction
  function automatic int nstop(input int i); return (i == 0) ? 1 : 2;    endfunction
  // RX falling edge of the start bit to the push edge
  function automatic int lat(input int i);
    return 3 + (1 + 8 + npar(i) + nstop(i) - 1) * cpb(i) + cpb(i) / 2 + 2;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step(input int i);
    logic [15:0] act, expv;
    logic pop, eo, eb;
    ent_t w;
    act = {busy[i], ovr[i], count[i], valid[i], ferr[i], perr[i], rx_data[i]};
    if (!RESET) begin
      mq[i].delete(); pend[i].delete(); biv[i].delete();
      expv = '0;
    end else begin
      eo  = 1'b0;
      pop = rdy_cap[i] && (mq[i].size() > 0);
      if (pend[i].size() > 0 && pend[i][0].cyc == cyc) begin
        w = pend[i].pop_front();
        if (mq[i].size() == 4 && !pop) eo = 1'b1;
        else begin
          if (pop) void'(mq[i].pop_front());
          mq[i].push_back(w);
          pop = 1'b0;
        end
      end
      if (pop) void'(mq[i].pop_front());
      while (biv[i].size() > 0 && biv[i][0].hi < cyc) void'(biv[i].pop_front());
      eb = (biv[i].size() > 0) && (biv[i][0].lo <= cyc);
      if (mq[i].size() > 0)
        expv = {eb, eo, 3'(mq[i].size()), 1'b1, mq[i][0].fe, mq[i][0].pe, mq[i][0].d};
      else
        expv = {eb, eo, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00};
    end
    chk((i == 0) ? "cycle_a" : "cycle_b", int'(act), int'(expv));
    if (valid[i] && !prev_valid[i]) rise_cyc[i] = cyc;
    prev_valid[i] = valid[i];
    ovr_cnt[i] += int'(ovr[i]);
  endtask

  initial begin
    forever begin
      @(posedge CLK);
      cyc++;
      for (int i = 0; i < NI; i++) rdy_cap[i] = rdy[i];
      @(negedge CLK);
      for (int i = 0; i < NI; i++) model_step(i);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic add_busy(input int i, input int lo, input int hi);
    iv_t v;
    v.lo = lo; v.hi = hi;
    biv[i].push_back(v);
  endtask

  task automatic send_frame(input int i, input logic [7:0] d, input logic pbit,
                            input logic stopv, output int e);
    ent_t w;
    int l;
    l = lat(i);
    e = cyc;
    w.cyc = e + l;
    w.d   = d;
    w.pe  = (npar(i) != 0) && (pbit != ^d);
    w.fe  = !stopv;
    pend[i].push_back(w);
    add_busy(i, e + 3, e + l - 1);
    // a low stop bit looks like a new start edge once the FSM is back in IDLE
    if (!stopv) add_busy(i, e + l + 1, e + l + cpb(i) / 2 + 2);
    rx[i] = 1'b0; tick(cpb(i));
    for (int b = 0; b < 8; b++) begin rx[i] = d[b]; tick(cpb(i)); end
    if (npar(i) != 0) begin rx[i] = pbit; tick(cpb(i)); end
    for (int s = 0; s < nstop(i); s++) begin
      rx[i] = (s == nstop(i) - 1) ? stopv : 1'b1;
      tick(cpb(i));
    end
    rx[i] = 1'b1;
  endtask

  task automatic drain(input int i, input int n);
    rdy[i] = 1'b1; tick(n); rdy[i] = 1'b0;
  endtask

  initial begin
    int e, e0, o0;
    logic [7:0] burst [4];
    burst[0] = 8'h32; burst[1] = 8'h2D; burst[2] = 8'h31; burst[3] = 8'h0D;
    for (int i = 0; i < NI; i++) begin
      rx[i] = 1'b1; rdy[i] = 1'b0; prev_valid[i] = 1'b0; rise_cyc[i] = 0; ovr_cnt[i] = 0;
    end
    RESET = 1'b1;
    #1 RESET = 1'b0;
    tick(5);
    chk("rst_count", int'(count[0]), 0);
    chk("rst_valid", int'(valid[0]), 0);
    chk("rst_busy", int'(busy[0]), 0);
    chk("rst_data", int'(rx_data[0]), 0);
    RESET = 1'b1;
    tick(10);

    // burst of "2-1\r" with READY low, then back-to-back reads
    e0 = cyc;
    for (int k = 0; k < 4; k++) send_frame(0, burst[k], 1'b0, 1'b1, e);
    tick(261);
    chk("burst_latency", rise_cyc[0] - e0, 2484);
    chk("burst_count", int'(count[0]), 4);
    chk("burst_head", int'(rx_data[0]), 8'h32);
    chk("burst_flags", int'({ferr[0], perr[0]}), 0);
    rdy[0] = 1'b1; tick(1);
    chk("burst_read1", int'(rx_data[0]), 8'h2D);
    chk("burst_count3", int'(count[0]), 3);
    tick(3); rdy[0] = 1'b0;
    chk("burst_empty_count", int'(count[0]), 0);
    chk("burst_empty_valid", int'(valid[0]), 0);

    // framing error, then a clean frame after the line settles
    send_frame(0, 8'h41, 1'b0, 1'b0, e);
    tick(3 * 261);
    chk("ferr_data", int'(rx_data[0]), 8'h41);
    chk("ferr_flag", int'(ferr[0]), 1);
    drain(0, 1);
    send_frame(0, 8'h42, 1'b0, 1'b1, e);
    tick(261);
    chk("ferr_clean_data", int'(rx_data[0]), 8'h42);
    chk("ferr_clean_flag", int'(ferr[0]), 0);
    drain(0, 1);

    // even parity, 2 stop bits: 0x32 has three ones, so the parity bit must be 1
    send_frame(1, 8'h32, 1'b1, 1'b1, e);
    tick(20);
    chk("par_latency", rise_cyc[1] - e, 189);
    chk("par_ok_data", int'(rx_data[1]), 8'h32);
    chk("par_ok_perr", int'(perr[1]), 0);
    drain(1, 1);
    send_frame(1, 8'h32, 1'b0, 1'b1, e);
    tick(20);
    chk("par_bad_data", int'(rx_data[1]), 8'h32);
    chk("par_bad_perr", int'(perr[1]), 1);
    drain(1, 1);

    // overrun: fifth word is dropped
    o0 = ovr_cnt[0];
    for (int k = 1; k <= 5; k++) send_frame(0, 8'(k), 1'b0, 1'b1, e);
    tick(261);
    chk("ovr_pulses", ovr_cnt[0] - o0, 1);
    chk("ovr_count", int'(count[0]), 4);
    chk("ovr_head", int'(rx_data[0]), 8'h01);
    drain(0, 4);
    chk("ovr_drained", int'(valid[0]), 0);

    // same, but READY pulses on the fifth push edge
    o0 = ovr_cnt[0];
    for (int k = 1; k <= 4; k++) send_frame(0, 8'h10 + 8'(k), 1'b0, 1'b1, e);
    fork
      send_frame(0, 8'h15, 1'b0, 1'b1, e);
      begin
        tick(2484 - 1);
        rdy[0] = 1'b1; tick(1); rdy[0] = 1'b0;
      end
    join
    tick(261);
    chk("ovr_pop_pulses", ovr_cnt[0] - o0, 0);
    chk("ovr_pop_count", int'(count[0]), 4);
    chk("ovr_pop_head", int'(rx_data[0]), 8'h12);
    drain(0, 4);

    // glitch: 100 low clocks is shorter than the start-bit vote point
    e = cyc;
    add_busy(0, e + 3, e + 3 + 261 / 2 + 1);
    rx[0] = 1'b0; tick(100);
    chk("glitch_busy_hi", int'(busy[0]), 1);
    rx[0] = 1'b1; tick(200);
    chk("glitch_busy_lo", int'(busy[0]), 0);
    chk("glitch_valid", int'(valid[0]), 0);
    send_frame(0, 8'h55, 1'b0, 1'b1, e);
    tick(261);
    chk("glitch_next_data", int'(rx_data[0]), 8'h55);
    drain(0, 1);

    // reset in the middle of the data bits of 0x32
    e = cyc;
    add_busy(0, e + 3, 32'h3FFF_FFFF);
    rx[0] = 1'b0; tick(261);
    rx[0] = 1'b0; tick(261);
    rx[0] = 1'b1; tick(261);
    rx[0] = 1'b0; tick(130);
    RESET = 1'b0; rx[0] = 1'b1;
    tick(3);
    chk("mid_rst_busy", int'(busy[0]), 0);
    chk("mid_rst_count", int'(count[0]), 0);
    chk("mid_rst_valid", int'(valid[0]), 0);
    RESET = 1'b1;
    tick(2 * 261);
    chk("mid_rst_nothing", int'(valid[0]), 0);
    send_frame(0, 8'h0D, 1'b0, 1'b1, e);
    tick(261);
    chk("mid_rst_next", int'(rx_data[0]), 8'h0D);
    drain(0, 1);
    tick(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
